aes_128_iter_core: RTL



---
 rtl/aes_128_iter_core.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_128_iter_core.sv
// -----------------------------------------------------------------------------
// aes_128_iter_core
//
// Iterative AES-128 encryption core. A plaintext/key pair is accepted, then a
// single shared round datapath (unrolled ROUNDS_PER_CYCLE times) is iterated
// with on-the-fly key expansion. The ciphertext is held until the consumer
// takes it. One block is in flight at a time.
//
// Parameters
//   ROUNDS_PER_CYCLE  AES rounds per clock: 1, 2, 5 or 10 (others rejected
//                     at elaboration).
//
// Optional feature (compile-time macro)
//   AES_OUT_REG_EN    adds a FLUSH state and a dedicated output register
//                     loaded in FLUSH, so the last-round logic does not reach
//                     the ciphertext port. Adds one cycle of latency.
//
// Ports
//   clk         in   1    rising-edge clock
//   rst         in   1    synchronous, active-high reset
//   in_valid    in   1    plaintext/key present
//   in_ready    out  1    core can accept a block (IDLE only, low in reset)
//   plaintext   in   128  byte 0 = bits [127:120], column-major
//   key         in   128  cipher key, same byte order
//   out_valid   out  1    ciphertext valid (DONE)
//   out_ready   in   1    consumer accepts ciphertext
//   ciphertext  out  128  result block, keeps last value until next result
//   busy        out  1    high in any state other than IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Inputs are sampled only on that edge; out_valid and ciphertext
// stay stable until the edge on which out_ready is seen high.
// -----------------------------------------------------------------------------
module aes_128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Round helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows together: output byte (row r, column c) comes from
  // input column (c + r) mod 4 of the same row.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = SBOX[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round key r from round key r-1: RotWord/SubWord on the last word, Rcon on
  // its first byte, then the running XOR across the four words.
  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                  input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;      // rounds completed for the current block
  logic [127:0] blk_q, blk_d;      // cipher state
  logic [127:0] rk_q, rk_d;        // round key of the last completed round
  logic [127:0] hold_q, hold_d;    // ciphertext shown outside DONE

  // ---------------------------------------------------------------------------
  // Unrolled round datapath: ROUNDS_PER_CYCLE rounds starting at rnd_q + 1.
  // Because 10 is a multiple of ROUNDS_PER_CYCLE, round 10 always lands in the
  // last unrolled stage of the final RUN cycle.
  // ---------------------------------------------------------------------------
  logic [127:0] dp_blk, dp_key, dp_sr;
  logic [3:0]   dp_rnum;

  always_comb begin
    dp_blk  = blk_q;
    dp_key  = rk_q;
    dp_sr   = '0;
    dp_rnum = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      dp_rnum = rnd_q + 4'(i + 1);
      dp_key  = next_round_key(dp_key, rcon_of(dp_rnum));
      dp_sr   = sub_shift(dp_blk);
      dp_blk  = ((dp_rnum == 4'd10) ? dp_sr : mix_columns(dp_sr)) ^ dp_key;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    rk_d      = rk_q;
    hold_d    = hold_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid) begin
          blk_d   = plaintext ^ key;
          rk_d    = key;
          rnd_d   = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        blk_d = dp_blk;
        rk_d  = dp_key;
        rnd_d = rnd_q + 4'(ROUNDS_PER_CYCLE);
        if (rnd_d == 4'd10) begin
`ifdef AES_OUT_REG_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef AES_OUT_REG_EN
      ST_FLUSH: begin
        hold_d  = blk_q;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifndef AES_OUT_REG_EN
          // Keep the result visible after leaving DONE, since blk_q is
          // overwritten by the next block's rounds.
          hold_d = blk_q;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AES_OUT_REG_EN
  assign ciphertext = hold_q;
`else
  assign ciphertext = (state_q == ST_DONE) ? blk_q : hold_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      rk_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      hold_q  <= hold_d;
    end
  end

endmodule
